button_debounce: RTL and testbench



---
 rtl/button_debounce_pkg.sv | 19 +
 rtl/button_debounce_if.sv | 13 +
 rtl/button_debounce_channel.sv | 65 ++++++
 rtl/button_debounce.sv | 42 ++++
 tb/tb_button_debounce.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/button_debounce_pkg.sv
// Shared constants, types and sizing helper for the push-button debouncer.
// Included by the channel sub-module and the top.
package button_debounce_pkg;

    localparam int BOARD_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms at 100 MHz
    localparam int SIM_DEBOUNCE_CYCLES   = 4;

    // Smallest counter width that can hold DEBOUNCE_CYCLES-1
    function automatic int min_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
    } chan_out_t;

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle between the board pins, the debouncer and its consumer.
// The debouncer takes the slave side; pin driver / consumer takes master.
interface button_debounce_if #(parameter int WIDTH = 2);

    logic [WIDTH-1:0] btn_in;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_press;
    logic [WIDTH-1:0] btn_release;

    modport master (output btn_in, input btn_level, btn_press, btn_release);
    modport slave  (input btn_in, output btn_level, btn_press, btn_release);

endinterface

// File: rtl/button_debounce_channel.sv
// One debounce channel: 2-FF synchronizer, stability counter, level register
// and press/release pulse registers (pulses only with BUTTON_DEBOUNCE_EDGE_EN).
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = 20,
    parameter bit INVERT          = 1'b0
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      pin,
    output chan_out_t out
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync0, sync1, s, level;
    logic [1:0]           primed;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 differ, accept;
    logic                 press, rel;

    assign s = sync1 ^ INVERT;

    // Synchronizer contents are not real pin samples for two cycles after
    // reset; with INVERT their zero reset value would look like a press.
    assign differ = (s != level) && primed[1];
    assign accept = differ && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            primed <= 2'b00;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync0  <= pin;
            sync1  <= sync0;
            primed <= {primed[0], 1'b1};
            if (!differ || accept) cnt <= '0;
            else                   cnt <= cnt + 1'b1;
            if (accept) level <= s;
        end
    end

`ifdef BUTTON_DEBOUNCE_EDGE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= accept &  s;
            rel   <= accept & ~s;
        end
    end
`else
    assign press = 1'b0;
    assign rel   = 1'b0;
`endif

    assign out = '{level: level, press: press, rel: rel};

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: WIDTH independent debounce channels.
// Define BUTTON_DEBOUNCE_EDGE_EN to get press/release pulses; otherwise tied 0.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
    parameter int CNT_WIDTH       = 20,
    parameter bit INVERT          = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    button_debounce_if.slave btn
);

    chan_out_t [WIDTH-1:0] ch;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH),
            .INVERT          (INVERT)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .pin   (btn.btn_in[i]),
            .out   (ch[i])
        );
    end

    always_comb begin
        btn.btn_level   = '0;
        btn.btn_press   = '0;
        btn.btn_release = '0;
        for (int i = 0; i < WIDTH; i++) begin
            btn.btn_level[i]   = ch[i].level;
            btn.btn_press[i]   = ch[i].press;
            btn.btn_release[i] = ch[i].rel;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench: DEBOUNCE_CYCLES=4, WIDTH=2; dut0 plain pins, dut1 active-low.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_button_debounce;
    import button_debounce_pkg::*;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
    localparam logic [1:0] PB = 2'b11;
`else
    localparam logic [1:0] PB = 2'b00;
`endif
    localparam int CW = min_cnt_width(SIM_DEBOUNCE_CYCLES);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    button_debounce_if #(.WIDTH(2)) bus0 ();
    button_debounce_if #(.WIDTH(2)) bus1 ();

    button_debounce #(.WIDTH(2), .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
                      .CNT_WIDTH(CW), .INVERT(1'b0))
        dut0 (.clk(clk), .reset(reset), .btn(bus0));

    button_debounce #(.WIDTH(2), .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
                      .CNT_WIDTH(CW), .INVERT(1'b1))
        dut1 (.clk(clk), .reset(reset), .btn(bus1));

    int checks = 0;
    int errors = 0;
    logic [1:0] win, lvl_seen, spur1;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, remembering any pulse/level seen on the way
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            win      |= bus0.btn_press | bus0.btn_release;
            lvl_seen |= bus0.btn_level;
            spur1    |= bus1.btn_press | bus1.btn_release;
        end
    endtask

    initial begin
        bus0.btn_in = 2'b00;
        bus1.btn_in = 2'b11;
        win = '0; lvl_seen = '0; spur1 = '0;

        tick(2);
        chk("rst_level0", bus0.btn_level, 2'b00);
        chk("rst_edges0", bus0.btn_press | bus0.btn_release, 2'b00);
        chk("rst_level1", bus1.btn_level, 2'b00);
        reset = 1'b0;

        tick(8);
        chk("inv_idle_level", bus1.btn_level, 2'b00);

        // clean press on both channels
        bus0.btn_in = 2'b11; win = '0;
        tick(5);
        chk("hold_early_level", bus0.btn_level, 2'b00);
        chk("hold_early_pulse", win, 2'b00);
        tick(1);
        chk("hold_level", bus0.btn_level, 2'b11);
        chk("hold_press", bus0.btn_press, PB);
        chk("hold_no_release", bus0.btn_release, 2'b00);
        tick(1);
        chk("press_one_cycle", bus0.btn_press, 2'b00);

        // asynchronous reset between clock edges
        #2 reset = 1'b1;
        #1;
        chk("async_rst_level", bus0.btn_level, 2'b00);
        chk("async_rst_press", bus0.btn_press, 2'b00);
        tick(1);
        reset = 1'b0; win = '0;
        tick(5);
        chk("post_rst_early", bus0.btn_level, 2'b00);
        tick(1);
        chk("post_rst_level", bus0.btn_level, 2'b11);
        chk("post_rst_press", bus0.btn_press, PB);

        // release both channels
        tick(1);
        bus0.btn_in = 2'b00; win = '0;
        tick(5);
        chk("rel_early_level", bus0.btn_level, 2'b11);
        chk("rel_early_pulse", win, 2'b00);
        tick(1);
        chk("rel_level", bus0.btn_level, 2'b00);
        chk("rel_pulse", bus0.btn_release, PB);
        chk("rel_no_press", bus0.btn_press, 2'b00);
        tick(1);
        chk("rel_one_cycle", bus0.btn_release, 2'b00);

        // reset while the counter sits at 2: the full count starts over
        bus0.btn_in = 2'b11;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0; win = '0;
        tick(5);
        chk("midrst_early", bus0.btn_level, 2'b00);
        chk("midrst_no_pulse", win, 2'b00);
        tick(1);
        chk("midrst_level", bus0.btn_level, 2'b11);
        chk("midrst_press", bus0.btn_press, PB);
        bus0.btn_in = 2'b00;
        tick(7);
        chk("idle_again", bus0.btn_level, 2'b00);

        // bounce 1,0,1,0 on channel 0, then hold
        win = '0;
        bus0.btn_in = 2'b01; tick(1);
        bus0.btn_in = 2'b00; tick(1);
        bus0.btn_in = 2'b01; tick(1);
        bus0.btn_in = 2'b00; tick(1);
        bus0.btn_in = 2'b01;
        tick(5);
        chk("bounce_early", bus0.btn_level, 2'b00);
        chk("bounce_no_pulse", win, 2'b00);
        tick(1);
        chk("bounce_level", bus0.btn_level, 2'b01);
        chk("bounce_press", bus0.btn_press, PB & 2'b01);

        // release channel 0
        bus0.btn_in = 2'b00;
        tick(1);
        win = '0;
        tick(4);
        chk("rel0_early_level", bus0.btn_level, 2'b01);
        chk("rel0_early_pulse", win, 2'b00);
        tick(1);
        chk("rel0_pulse", bus0.btn_release, PB & 2'b01);
        chk("rel0_no_press", bus0.btn_press, 2'b00);
        chk("rel0_level", bus0.btn_level, 2'b00);
        tick(1);
        chk("rel0_one_cycle", bus0.btn_release, 2'b00);

        // 3-cycle glitch on channel 1 is rejected
        win = '0; lvl_seen = '0;
        bus0.btn_in = 2'b10; tick(3);
        bus0.btn_in = 2'b00; tick(10);
        chk("glitch_level", lvl_seen, 2'b00);
        chk("glitch_pulses", win, 2'b00);

        // exactly 4 cycles is accepted
        bus0.btn_in = 2'b10; tick(4);
        bus0.btn_in = 2'b00; tick(2);
        chk("pulse4_level", bus0.btn_level, 2'b10);
        chk("pulse4_press", bus0.btn_press, PB & 2'b10);
        tick(8);
        chk("pulse4_fall", bus0.btn_level, 2'b00);

        // active-low pins: no spurious pulse so far, then a real press
        chk("inv_no_spurious", spur1, 2'b00);
        bus1.btn_in = 2'b00;
        tick(5);
        chk("inv_early", bus1.btn_level, 2'b00);
        tick(1);
        chk("inv_level", bus1.btn_level, 2'b11);
        chk("inv_press", bus1.btn_press, PB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
